// File: rtl/pet_evt_pkg.sv
// Shared event ids, widths and FSM encoding for the pet event scheduler.
package pet_evt_pkg;

    localparam int ID_W = 3;

    localparam int EV_AWAKING = 0;
    localparam int EV_PRESSED = 1;
    localparam int EV_TOUCHED = 2;
    localparam int EV_PETTING = 3;
    localparam int EV_UP      = 4;
    localparam int EV_DOWN    = 5;
    localparam int EV_LEFT    = 6;
    localparam int EV_RIGHT   = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        COOLDOWN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pet_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins.
module pet_prio_enc
    import pet_evt_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  idx,
    output logic             any_set
);

    always_comb begin
        idx     = '0;
        any_set = |req;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/pet_event_scheduler.sv
// Latches sensor event pulses and dispatches them one at a time by fixed
// priority over valid/ready, with a cooldown gap after each accepted event.
module pet_event_scheduler
    import pet_evt_pkg::*;
#(
    parameter int N_SRC        = 8,
    parameter int COOLDOWN_CYC = 25_000_000,
    parameter int CNT_W        = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] ev_pulse,
    input  logic             enable,
    output logic             ev_valid,
    output logic [ID_W-1:0]  ev_id,
    input  logic             ev_ready,
    output logic [N_SRC-1:0] pending,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam logic [CNT_W-1:0] CD_LAST =
        (COOLDOWN_CYC == 0) ? '0 : CNT_W'(COOLDOWN_CYC - 1);

    sched_state_t      state, state_nxt;
    logic [CNT_W-1:0]  cd_cnt;
    logic [ID_W-1:0]   sel_id;
    logic              sel_any;
    logic              hs;
    logic [N_SRC-1:0]  set_v, clr_v, dup_v, pending_nxt;
    logic [8:0]        drop_sum;
    logic [7:0]        drop_nxt;

    pet_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req     (pending),
        .idx     (sel_id),
        .any_set (sel_any)
    );

    assign hs = ev_valid & ev_ready;

    // A pulse landing on a bit being cleared this cycle re-arms it and is not a drop.
    always_comb begin
        clr_v = '0;
        if (hs) clr_v[ev_id] = 1'b1;
        set_v       = enable ? ev_pulse : '0;
        dup_v       = set_v & pending & ~clr_v;
        pending_nxt = (pending & ~clr_v) | set_v;
        drop_sum    = {1'b0, drop_cnt} + 9'($countones(dup_v));
        drop_nxt    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cd_cnt   <= '0;
            ev_id    <= '0;
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            drop_cnt <= drop_nxt;
            if (state == IDLE && enable && sel_any) ev_id <= sel_id;
            if (hs)                        cd_cnt <= '0;
            else if (state == COOLDOWN)    cd_cnt <= cd_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable && sel_any) state_nxt = OFFER;
            OFFER:    if (ev_ready) state_nxt = (COOLDOWN_CYC == 0) ? IDLE : COOLDOWN;
            COOLDOWN: if (cd_cnt == CD_LAST) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ev_valid = (state == OFFER);
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_pet_event_scheduler.sv
// Directed bench for pet_event_scheduler with a 4-cycle cooldown.
module tb_pet_event_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ev_pulse;
    logic       enable;
    logic       ev_valid;
    logic [2:0] ev_id;
    logic       ev_ready;
    logic [7:0] pending;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pet_event_scheduler #(.N_SRC(8), .COOLDOWN_CYC(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_pulse (ev_pulse),
        .enable   (enable),
        .ev_valid (ev_valid),
        .ev_id    (ev_id),
        .ev_ready (ev_ready),
        .pending  (pending),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // advance one edge; inputs driven and outputs sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        ev_pulse = v;
        step();
        ev_pulse = '0;
    endtask

    task automatic wait_offer(output bit found);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (ev_valid === 1'b1) begin
                found = 1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(output bit found);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b0) begin
                found = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 0; ev_pulse = '0; enable = 1; ev_ready = 0;
        step(); step();
        rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if ({ev_valid, pending, drop_cnt, busy} !== 18'd0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d: valid=%b pending=%h drop=%0d busy=%b, want all 0",
                         i, ev_valid, pending, drop_cnt, busy);
            end
        end
    endtask

    task automatic test_single();
        ev_ready = 1;
        pulse(8'h04);
        n_cmp++;
        if (pending !== 8'h04 || ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latch: pending=%h valid=%b, want 04/0", pending, ev_valid);
        end
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_id !== 3'd2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_offer: valid=%b id=%0d busy=%b, want 1/2/1", ev_valid, ev_id, busy);
        end
        step();
        n_cmp++;
        if (ev_valid !== 1'b0 || busy !== 1'b1 || pending !== 8'h00) begin
            n_err++;
            $display("FAIL single_accept: valid=%b busy=%b pending=%h, want 0/1/00", ev_valid, busy, pending);
        end
        for (int i = 1; i < 4; i++) begin
            step();
            n_cmp++;
            if (busy !== 1'b1 || ev_valid !== 1'b0) begin
                n_err++;
                $display("FAIL single_cooldown cyc=%0d: busy=%b valid=%b, want 1/0", i, busy, ev_valid);
            end
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_cooldown_end: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_priority();
        bit ok;
        ev_ready = 0;
        pulse(8'h22);
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_id !== 3'd1) begin
            n_err++;
            $display("FAIL prio_first: valid=%b id=%0d, want 1/1", ev_valid, ev_id);
        end
        pulse(8'h01);
        step(); step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_id !== 3'd1 || pending !== 8'h23) begin
            n_err++;
            $display("FAIL prio_hold: valid=%b id=%0d pending=%h, want 1/1/23", ev_valid, ev_id, pending);
        end
        ev_ready = 1;
        step();
        n_cmp++;
        if (pending !== 8'h21 || ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL prio_accept: pending=%h valid=%b, want 21/0", pending, ev_valid);
        end
        wait_offer(ok);
        n_cmp++;
        if (!ok || ev_id !== 3'd0) begin
            n_err++;
            $display("FAIL prio_second: found=%0d id=%0d, want 1/0", ok, ev_id);
        end
        step();
        wait_offer(ok);
        n_cmp++;
        if (!ok || ev_id !== 3'd5) begin
            n_err++;
            $display("FAIL prio_third: found=%0d id=%0d, want 1/5", ok, ev_id);
        end
        step();
        wait_idle(ok);
        n_cmp++;
        if (!ok || pending !== 8'h00) begin
            n_err++;
            $display("FAIL prio_drain: found=%0d pending=%h, want 1/00", ok, pending);
        end
    endtask

    task automatic test_drops();
        bit ok;
        ev_ready = 1;
        pulse(8'h80);
        step();
        step();
        ev_ready = 0;
        n_cmp++;
        if (busy !== 1'b1 || ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drop_in_cooldown: busy=%b valid=%b, want 1/0", busy, ev_valid);
        end
        pulse(8'h08); pulse(8'h08); pulse(8'h08);
        n_cmp++;
        if (pending[3] !== 1'b1 || drop_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL drop_three: pending3=%b drop=%0d, want 1/2", pending[3], drop_cnt);
        end
        ev_pulse = 8'h08;
        for (int i = 0; i < 300; i++) step();
        ev_pulse = '0;
        n_cmp++;
        if (drop_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL drop_saturate: drop=%0d, want 255", drop_cnt);
        end
        ev_ready = 1;
        step();
        wait_idle(ok);
        n_cmp++;
        if (!ok || pending !== 8'h00) begin
            n_err++;
            $display("FAIL drop_drain: found=%0d pending=%h, want 1/00", ok, pending);
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        rst_n = 0;
        step();
        rst_n = 1;
        n_cmp++;
        if (drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL same_reset_drop: drop=%0d, want 0", drop_cnt);
        end
        ev_ready = 0;
        pulse(8'h10);
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_id !== 3'd4) begin
            n_err++;
            $display("FAIL same_offer: valid=%b id=%0d, want 1/4", ev_valid, ev_id);
        end
        ev_ready = 1;
        pulse(8'h10);
        n_cmp++;
        if (pending !== 8'h10 || drop_cnt !== 8'd0 || ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL same_set_wins: pending=%h drop=%0d valid=%b, want 10/0/0", pending, drop_cnt, ev_valid);
        end
        wait_offer(ok);
        n_cmp++;
        if (!ok || ev_id !== 3'd4) begin
            n_err++;
            $display("FAIL same_reoffer: found=%0d id=%0d, want 1/4", ok, ev_id);
        end
        step();
        wait_idle(ok);
        n_cmp++;
        if (!ok || pending !== 8'h00 || drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL same_drain: found=%0d pending=%h drop=%0d, want 1/00/0", ok, pending, drop_cnt);
        end
    endtask

    task automatic test_enable_reset();
        enable = 0;
        pulse(8'h40);
        step();
        n_cmp++;
        if (pending !== 8'h00 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL enable_off: pending=%h busy=%b drop=%0d, want 00/0/0", pending, busy, drop_cnt);
        end
        enable = 1;
        ev_ready = 0;
        pulse(8'h40);
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_id !== 3'd6) begin
            n_err++;
            $display("FAIL enable_on_offer: valid=%b id=%0d, want 1/6", ev_valid, ev_id);
        end
        rst_n = 0;
        step();
        n_cmp++;
        if (ev_valid !== 1'b0 || pending !== 8'h00 || busy !== 1'b0 || ev_id !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid_offer: valid=%b pending=%h busy=%b id=%0d, want 0/00/0/0",
                     ev_valid, pending, busy, ev_id);
        end
        rst_n = 1;
        step();
        n_cmp++;
        if (ev_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after: valid=%b busy=%b, want 0/0", ev_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_drops();
        test_same_cycle();
        test_enable_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pet_event_scheduler.md
Name: pet_event_scheduler

Overview:
- Collects one-cycle interaction pulses from the sensor front-ends: gyro awaking, touch, sonic petting/expecting, joystick pressed/up/down/left/right.
- Latches each pulse as a pending request and dispatches exactly one event at a time to the screen/animation logic over a valid/ready handshake.
- Selects between pending events by fixed priority and enforces a cooldown between dispatches, so animations are not overrun.
- Sits between the one_pulse-conditioned sensor outputs and screen_top.

Parameters:
- N_SRC, 8, number of event sources; ev_id width is 3.
- COOLDOWN_CYC, 25_000_000, idle cycles after each accepted event (0.25 s at 100 MHz); 0 disables cooldown.
- CNT_W, 25, cooldown counter width; must hold COOLDOWN_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- ev_pulse  in  N_SRC  one-cycle event pulses; bit index = event id, bit 0 highest priority
- enable  in  1  1 = latch pulses and start dispatches
- ev_valid  out  1  event offered to consumer
- ev_id  out  3  id of the offered event; stable while ev_valid=1
- ev_ready  in  1  consumer accepts; handshake = ev_valid & ev_ready
- pending  out  N_SRC  current pending bit vector
- busy  out  1  1 in OFFER or COOLDOWN
- drop_cnt  out  8  saturating count of pulses lost because their id was already pending

Behaviour:
- Reset (rst_n=0 at a clk edge): pending=0, ev_valid=0, ev_id=0, busy=0, drop_cnt=0, cooldown counter=0, FSM=IDLE. This applies mid-OFFER or mid-COOLDOWN; the in-flight event is discarded.
- Pending latch, per bit i each cycle:
  - enable=1 & ev_pulse[i]: set.
  - Cleared only by a handshake on id i.
  - Handshake clear and a new pulse on the same i in the same cycle: the set wins, and drop_cnt is not incremented.
  - ev_pulse[i]=1 while pending[i]=1 and no clear that cycle: drop_cnt +1, saturating at 255.
  - enable=0: pulses are ignored and not counted; existing pending bits are retained.
- FSM IDLE:
  - If enable=1 and pending≠0: latch ev_id = lowest set index, go to OFFER.
  - Otherwise stay in IDLE.
- FSM OFFER:
  - ev_valid=1 and ev_id held constant; enable is ignored here, so an offer already started completes.
  - On handshake: clear pending[ev_id], drop ev_valid the next cycle, go to COOLDOWN with counter=0. If COOLDOWN_CYC=0, go to IDLE instead.
  - No timeout: ev_valid waits indefinitely for ev_ready.
- FSM COOLDOWN:
  - Counter increments each cycle; ev_valid=0.
  - When counter == COOLDOWN_CYC-1, go to IDLE, so exactly COOLDOWN_CYC cycles are spent in COOLDOWN.
  - Pulses continue to latch during COOLDOWN.
- Latency:
  - Pulse sampled at edge t → pending visible after t.
  - If the FSM is IDLE, it enters OFFER at edge t+1, so ev_valid=1 in the cycle after t+1.
- Back-to-back with COOLDOWN_CYC=0: handshake at edge h → IDLE after h → the next OFFER is entered at h+1. At most one event per 2 cycles.
- Priority: re-evaluated only in IDLE. A higher-priority pulse arriving during OFFER does not preempt ev_id.
- busy = (FSM≠IDLE).

Decomposition:
- Package pet_evt_pkg:
  - Event id localparams: EV_AWAKING=0, EV_PRESSED=1, EV_TOUCHED=2, EV_PETTING=3, EV_UP=4, EV_DOWN=5, EV_LEFT=6, EV_RIGHT=7.
  - FSM state encoding: IDLE=2'd0, OFFER=2'd1, COOLDOWN=2'd2.
- Sub-module pet_prio_enc: combinational lowest-set-bit encoder (N_SRC→3 bits plus any_set). This is the only natural split.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then release with no pulses → ev_valid=0, pending=0, drop_cnt=0, busy=0 for 20 cycles.
- Single dispatch with COOLDOWN_CYC=4, ev_ready tied 1: pulse bit 2 → ev_valid high exactly 1 cycle with ev_id=2, 2 edges after the pulse. Then busy=1 for 4 cooldown cycles, then busy=0.
- Priority and hold, ev_ready=0:
  - Pulse bits 5 and 1 in the same cycle → ev_id=1 is offered.
  - Pulse bit 0 during the offer → ev_id stays 1.
  - Raise ev_ready → after cooldown the next offer is ev_id=0, then ev_id=5.
- Drops: pulse bit 3 three times while the FSM is in COOLDOWN → pending[3]=1, drop_cnt=2. Drive 300 duplicate pulses → drop_cnt saturates at 255.
- Same-cycle clear and set: pulse bit 4 in the handshake cycle of ev_id=4 → pending[4] remains 1, drop_cnt unchanged, ev_id=4 is offered again after cooldown.
- enable and reset mid-operation:
  - enable=0 and pulse bit 6 → pending[6]=0.
  - Assert rst_n=0 during OFFER → the next cycle ev_valid=0 and pending=0.
